// File: rtl/ap_fu_arb_pkg.sv
// Shared types and default widths for the ap_ctrl_hs functional-unit arbiter.
//   arb_state_t : arbiter sequencing states
//   DEF_*       : default parameter values used by the arbiter and its users
package ap_fu_arb_pkg;

    localparam int unsigned DEF_NUM_REQ = 4;
    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_OP_W    = 4;
    localparam int unsigned DEF_LAT_W   = 16;

    // Handshake sequencing: pick a winner, drive ap_start, wait for ap_done, respond.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        RESP      = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner selection.
// Ports:
//   req       : per-requester request bits
//   ptr       : index that has highest priority this cycle
//   gnt_c     : one-hot winner (all zeros when nothing requests)
//   gnt_idx_c : binary index of the winner (0 when nothing requests)
//   any_c     : a winner exists
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt_c,
    output logic [IDX_W-1:0]   gnt_idx_c,
    output logic               any_c
);

    logic [IDX_W-1:0] cand;

    // Walk the requesters starting at ptr, wrapping modulo NUM_REQ; first hit wins.
    always_comb begin
        gnt_c     = '0;
        gnt_idx_c = '0;
        any_c     = 1'b0;
        cand      = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = IDX_W'((32'(ptr) + off) % NUM_REQ);
            if (!any_c && req[cand]) begin
                any_c       = 1'b1;
                gnt_c[cand] = 1'b1;
                gnt_idx_c   = cand;
            end
        end
    end

endmodule

// File: rtl/ap_fu_arbiter.sv
// Shares one ap_ctrl_hs functional unit between NUM_REQ requesters.
// Round-robin grant in IDLE, operand latch, ap_start/ap_ready/ap_done
// sequencing, one-cycle response strobe and a saturating latency counter.
// Ports:
//   clock, reset          : clock and synchronous active-high reset
//   req_valid/op/a/b      : packed per-requester requests (slice i at i*W)
//   req_ready             : one-hot acceptance, combinational while IDLE
//   rsp_valid, rsp_data   : one-hot one-cycle result strobe and result
//   fu_ap_start/op/a/b    : registered start and held operands to the FU
//   fu_ap_ready/done      : FU handshake inputs
//   fu_ap_return          : FU result
//   busy, grant_id        : not-IDLE flag and current/last winner index
//   last_latency          : START-entry-to-done cycles of the last op
module ap_fu_arbiter
    import ap_fu_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned OP_W    = DEF_OP_W,
    parameter int unsigned LAT_W   = DEF_LAT_W
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*OP_W-1:0]      req_op,
    input  logic [NUM_REQ*DATA_W-1:0]    req_a,
    input  logic [NUM_REQ*DATA_W-1:0]    req_b,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [DATA_W-1:0]            rsp_data,
    output logic                         fu_ap_start,
    input  logic                         fu_ap_ready,
    input  logic                         fu_ap_done,
    output logic [OP_W-1:0]              fu_op,
    output logic [DATA_W-1:0]            fu_a,
    output logic [DATA_W-1:0]            fu_b,
    input  logic [DATA_W-1:0]            fu_ap_return,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic [LAT_W-1:0]             last_latency
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    arb_state_t       state_q;
    arb_state_t       state_d;
    logic [IDX_W-1:0] ptr_q;
    logic [LAT_W-1:0] lat_cnt_q;
    logic [LAT_W-1:0] lat_inc_c;

    logic [NUM_REQ-1:0] win_gnt_c;
    logic [IDX_W-1:0]   win_idx_c;
    logic               win_any_c;

    logic accept_c;
    logic in_op_c;
    logic done_edge_c;

    logic [OP_W-1:0]   op_arr [NUM_REQ];
    logic [DATA_W-1:0] a_arr  [NUM_REQ];
    logic [DATA_W-1:0] b_arr  [NUM_REQ];

    // Unpack the flat request buses so the winner can be selected by index.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign op_arr[i] = req_op[i*OP_W +: OP_W];
        assign a_arr[i]  = req_a[i*DATA_W +: DATA_W];
        assign b_arr[i]  = req_b[i*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req       (req_valid),
        .ptr       (ptr_q),
        .gnt_c     (win_gnt_c),
        .gnt_idx_c (win_idx_c),
        .any_c     (win_any_c)
    );

    // Saturating increment shared by the running counter and the done capture.
    assign lat_inc_c = (&lat_cnt_q) ? lat_cnt_q : lat_cnt_q + LAT_W'(1);

    // Next state, acceptance and the combinational ready vector.
    always_comb begin
        state_d     = state_q;
        req_ready   = '0;
        accept_c    = 1'b0;
        in_op_c     = 1'b0;
        done_edge_c = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = win_gnt_c;
                if (win_any_c) begin
                    accept_c = 1'b1;
                    state_d  = START;
                end
            end
            START: begin
                in_op_c = 1'b1;
                // ap_done in START also implies the inputs were consumed.
                if (fu_ap_done) begin
                    done_edge_c = 1'b1;
                    state_d     = RESP;
                end else if (fu_ap_ready) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                in_op_c = 1'b1;
                if (fu_ap_done) begin
                    done_edge_c = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, pointer, operand latch, response and latency registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            lat_cnt_q    <= '0;
            busy         <= 1'b0;
            fu_ap_start  <= 1'b0;
            rsp_valid    <= '0;
            rsp_data     <= '0;
            fu_op        <= '0;
            fu_a         <= '0;
            fu_b         <= '0;
            grant_id     <= '0;
            last_latency <= '0;
        end else begin
            state_q     <= state_d;
            busy        <= (state_d != IDLE);
            fu_ap_start <= (state_d == START);
            // grant_id is already stable when RESP is entered from START/WAIT_DONE.
            rsp_valid   <= (state_d == RESP) ? (NUM_REQ'(1) << grant_id) : '0;

            if (accept_c) begin
                fu_op     <= op_arr[win_idx_c];
                fu_a      <= a_arr[win_idx_c];
                fu_b      <= b_arr[win_idx_c];
                grant_id  <= win_idx_c;
                ptr_q     <= (win_idx_c == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx_c + IDX_W'(1);
                lat_cnt_q <= '0;
            end else if (in_op_c) begin
                lat_cnt_q <= lat_inc_c;
            end

            if (done_edge_c) begin
                rsp_data     <= fu_ap_return;
                last_latency <= lat_inc_c;
            end
        end
    end

endmodule

// File: doc/ap_fu_arbiter.md
# ap_fu_arbiter

Shares one `ap_ctrl_hs` HLS functional unit, such as the 32-bit integer ALU op block inside the `hart` core, between `NUM_REQ` requesters. It grants requesters round-robin and latches the winner's opcode and operands. It then sequences the unit's `ap_start`/`ap_ready`/`ap_done` handshake and returns `ap_return` to the granted requester as a one-cycle response. A saturating per-operation latency counter is exported so the team's dataflow/status monitors can sample it.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 32: operand and result width.
- `OP_W`, 4: opcode width (funct3 plus alt bit).
- `LAT_W`, 16: latency counter width.

Ports:
- `clock` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in `NUM_REQ`: per-requester request.
- `req_op` in `NUM_REQ*OP_W`: packed opcodes; requester i at `[i*OP_W +: OP_W]`.
- `req_a` in `NUM_REQ*DATA_W`: packed operand A.
- `req_b` in `NUM_REQ*DATA_W`: packed operand B.
- `req_ready` out `NUM_REQ`: one-hot acceptance; combinational in IDLE.
- `rsp_valid` out `NUM_REQ`: one-hot, one-cycle result strobe.
- `rsp_data` out `DATA_W`: result, valid only while any `rsp_valid` bit is set.
- `fu_ap_start` out 1: registered start to the FU.
- `fu_ap_ready` in 1: FU accepted its inputs.
- `fu_ap_done` in 1: FU result valid.
- `fu_op` out `OP_W`: latched opcode driven to the FU.
- `fu_a` out `DATA_W`: latched operand A.
- `fu_b` out `DATA_W`: latched operand B.
- `fu_ap_return` in `DATA_W`: FU result.
- `busy` out 1: high in any state except IDLE.
- `grant_id` out `$clog2(NUM_REQ)`: index of the current or last granted requester.
- `last_latency` out `LAT_W`: cycles from START entry to done for the last completed op.

## Operation
- States and transitions:
  - IDLE to START when a winner exists.
  - START to WAIT_DONE on `fu_ap_ready & ~fu_ap_done`.
  - START to RESP on `fu_ap_done`.
  - WAIT_DONE to RESP on `fu_ap_done`.
  - RESP to IDLE unconditionally.
- Arbitration in IDLE:
  - Search `req_valid` starting at `ptr`, wrapping modulo `NUM_REQ`.
  - The winner's `req_ready` bit is high in the same cycle; all other bits are 0.
  - Outside IDLE, `req_ready` is all zeros.
- Accept edge: latch `fu_op/fu_a/fu_b` from the winner's slice; set `grant_id`; set `ptr = (winner+1) mod NUM_REQ`.
- START:
  - `fu_ap_start` = 1, held until an edge with `fu_ap_ready` or `fu_ap_done` high. `fu_ap_done` in START counts as ready.
  - Operand outputs are held constant from accept until RESP exits.
- Result capture: on the done edge, register `fu_ap_return` into `rsp_data`.
- RESP: `rsp_valid[grant_id]` = 1 for exactly one cycle. Requesters must not back-pressure.
- Latency counter:
  - Clears on START entry and increments each cycle in START/WAIT_DONE, saturating at all-ones.
  - On the done edge, `last_latency` takes count+1.
- `fu_ap_done` outside START/WAIT_DONE is ignored.
- A requester whose `req_valid` drops before grant is simply skipped; there is no memory of it.

## Timing
- Reset values:
  - All outputs 0 (`req_ready`, `rsp_valid`, `rsp_data`, `fu_ap_start`, `fu_op`, `fu_a`, `fu_b`, `busy`, `grant_id`, `last_latency`).
  - `ptr` = 0; state IDLE.
- Reset mid-operation aborts the op with no response. The FU must share the same `reset`.
- Combinational FU (ready and done on the first START cycle):
  - Accept at edge k; START during cycle k+1.
  - RESP (`rsp_valid`) in cycle k+2, IDLE in cycle k+3.
  - Peak throughput: one op per 3 cycles.
- FU with latency L (done L cycles after ready): `rsp_valid` in cycle k+2+L; `last_latency` = L+1.
- Simultaneous requests from all requesters are served in order `ptr`, `ptr`+1, … with no starvation. Worst-case wait is (`NUM_REQ`−1) operations.

## Structure
- Package `ap_fu_arb_pkg`: state enum (IDLE, START, WAIT_DONE, RESP) and default width constants.
- Sub-module `rr_arbiter`: combinational one-hot/index winner from `req` and `ptr`, parameterised by `NUM_REQ`. The pointer register stays in the top module.

## Test plan
- Single request: `req_valid` = 0001, a=5, b=7, op=ADD, combinational FU → `req_ready` = 0001 in cycle 0; `rsp_valid` = 0001 with `rsp_data` = 12 in cycle 2; `last_latency` = 1.
- All four requesting continuously from reset → grants 0,1,2,3,0 with `rsp_valid` every 3 cycles; no `req_ready` outside IDLE.
- FU with ready at START cycle 1 and done 4 cycles later → `fu_ap_start` high exactly 2 cycles; `last_latency` = 6; operands stable throughout.
- Stray `fu_ap_done` pulse while IDLE → no `rsp_valid`, no state change.
- `reset` asserted during WAIT_DONE → next cycle all outputs 0, state IDLE, no response. A following request to requester 2 is granted with `ptr` restarted at 0.
- FU stalls 70000 cycles (`LAT_W` = 16) → `last_latency` = 65535 (saturated); the response is still delivered.
